// File: rtl/clave_pkg.sv
// Shared defaults and FSM encoding for the 3-2 son clave beat decoder.
// No logic lives here; parameters of the decoder default to these values.
package clave_pkg;

  localparam int CNT_W = 13;
  localparam int IDX_W = 3;
  localparam int LED_W = 16;

  localparam logic [CNT_W-1:0] DEF_MAXCOUNT = 13'd6600;
  localparam logic [CNT_W-1:0] DEF_POS0     = 13'd0;
  localparam logic [CNT_W-1:0] DEF_POS1     = 13'd1236;
  localparam logic [CNT_W-1:0] DEF_POS2     = 13'd2472;
  localparam logic [CNT_W-1:0] DEF_POS3     = 13'd4120;
  localparam logic [CNT_W-1:0] DEF_POS4     = 13'd4944;
  localparam logic [LED_W-1:0] DEF_LED_LEN  = 16'd1000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARMED = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/clave_beat_decoder_if.sv
// Bar-position inputs and beat/LED outputs of the clave decoder.
// master = bar-counter side driving count/go, slave = the decoder.
interface clave_beat_decoder_if;
  import clave_pkg::*;

  logic [CNT_W-1:0] count;
  logic             go;
  logic             strike;
  logic [IDX_W-1:0] beat_idx;
  logic             led;
  logic             bar_done;

  modport master (output count, go, input strike, beat_idx, led, bar_done);
  modport slave  (input count, go, output strike, beat_idx, led, bar_done);

endinterface

// File: rtl/led_stretch.sv
// Retriggerable pulse stretcher: led high for LED_LEN cycles starting with the trig edge.
// Registered output; a new trig always reloads the full length. No backpressure.
module led_stretch
  import clave_pkg::*;
#(
  parameter logic [LED_W-1:0] LED_LEN = DEF_LED_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  output logic led
);

  logic [LED_W-1:0] cnt;

  // led mirrors (cnt != 0) but is kept as its own flop so the output is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      led <= 1'b0;
    end else if (trig) begin
      cnt <= LED_LEN;
      led <= (LED_LEN != '0);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      led <= (cnt > 16'd1);
    end
  end

endmodule

// File: rtl/clave_beat_decoder.sv
// Tracks bar position and emits one strike per 3-2 son clave beat, plus bar_done and an LED.
// Strike/bar_done one cycle after the triggering count; all outputs registered, no backpressure.
module clave_beat_decoder
  import clave_pkg::*;
#(
  parameter logic [CNT_W-1:0] MAXCOUNT = DEF_MAXCOUNT,
  parameter logic [LED_W-1:0] LED_LEN  = DEF_LED_LEN,
  parameter logic [CNT_W-1:0] POS0     = DEF_POS0,
  parameter logic [CNT_W-1:0] POS1     = DEF_POS1,
  parameter logic [CNT_W-1:0] POS2     = DEF_POS2,
  parameter logic [CNT_W-1:0] POS3     = DEF_POS3,
  parameter logic [CNT_W-1:0] POS4     = DEF_POS4
) (
  input logic                 clk,
  input logic                 reset,
  clave_beat_decoder_if.slave bus
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] prev_q;
  logic [CNT_W-1:0] pos_sel;
  logic             strike_q, strike_d;
  logic             done_q, done_d;
  logic             fired_q, fired_d;
  logic             wrap;

  always_comb begin
    case (idx_q)
      3'd0:    pos_sel = POS0;
      3'd1:    pos_sel = POS1;
      3'd2:    pos_sel = POS2;
      3'd3:    pos_sel = POS3;
      3'd4:    pos_sel = POS4;
      default: pos_sel = MAXCOUNT;
    endcase
  end

  assign wrap = (bus.count < prev_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    strike_d = 1'b0;
    done_d   = 1'b0;
    fired_d  = fired_q;
    if (bus.go) begin
      state_d = ST_ARMED;
      idx_d   = '0;
      fired_d = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (wrap) begin
            idx_d   = '0;
            fired_d = 1'b0;
          end else if (bus.count >= pos_sel) begin
            strike_d = 1'b1;
            idx_d    = idx_q + 3'd1;
            if (idx_q == 3'd4) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (wrap) begin
            state_d = ST_ARMED;
            idx_d   = '0;
            fired_d = 1'b0;
          end else if (bus.count == MAXCOUNT && !fired_q) begin
            done_d  = 1'b1;
            fired_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // go also clears the bar counter, so the following count of 0 must not read as a wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      prev_q   <= '0;
      strike_q <= 1'b0;
      done_q   <= 1'b0;
      fired_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      prev_q   <= bus.go ? '0 : bus.count;
      strike_q <= strike_d;
      done_q   <= done_d;
      fired_q  <= fired_d;
    end
  end

  led_stretch #(.LED_LEN(LED_LEN)) u_led (
    .clk   (clk),
    .reset (reset),
    .trig  (strike_d),
    .led   (bus.led)
  );

  assign bus.strike   = strike_q;
  assign bus.beat_idx = idx_q;
  assign bus.bar_done = done_q;

endmodule

// File: tb/tb_clave_beat_decoder.sv
// Directed table plus hand sequences for the clave beat decoder at default parameters.
module tb_clave_beat_decoder;

  typedef struct {
    logic        rst;
    logic        go;
    logic [12:0] cnt;
    logic        strike;
    logic [2:0]  idx;
    logic        led;
    logic        done;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  clave_beat_decoder_if bus ();

  clave_beat_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  vec_t tv[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic g, input logic [12:0] c);
    reset     = r;
    bus.go    = g;
    bus.count = c;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic g, input int c,
                              input logic s, input int i, input logic l, input logic d);
    vec_t v;
    v.rst = r; v.go = g; v.cnt = 13'(c);
    v.strike = s; v.idx = 3'(i); v.led = l; v.done = d;
    tv.push_back(v);
  endfunction

  int nstr, ndone, done_at, bad, lows, moves, nz;
  logic [2:0] pidx;
  logic exp_s;
  logic [12:0] cur;
  logic [12:0] posl[4];
  logic [12:0] rampl[8];

  initial begin
    bus.go = 1'b0;
    bus.count = '0;

    //   rst go cnt    strike idx led done
    add(1, 0, 0,     0, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0);
    add(0, 0, 5000,  0, 0, 0, 0);
    add(0, 1, 0,     0, 0, 0, 0);
    add(0, 0, 0,     1, 1, 1, 0);
    add(0, 0, 1,     0, 1, 1, 0);
    add(0, 0, 1235,  0, 1, 1, 0);
    add(0, 0, 1236,  1, 2, 1, 0);
    add(0, 0, 1236,  0, 2, 1, 0);
    add(0, 0, 2471,  0, 2, 1, 0);
    add(0, 0, 2472,  1, 3, 1, 0);
    add(0, 0, 4120,  1, 4, 1, 0);
    add(0, 0, 4944,  1, 5, 1, 0);
    add(0, 0, 6599,  0, 5, 1, 0);
    add(0, 0, 6600,  0, 5, 1, 1);
    add(0, 0, 6600,  0, 5, 1, 0);
    add(0, 0, 0,     0, 0, 1, 0);
    add(0, 0, 0,     1, 1, 1, 0);

    foreach (tv[k]) begin
      step(tv[k].rst, tv[k].go, tv[k].cnt);
      chk($sformatf("tv%0d_strike", k), int'(bus.strike), int'(tv[k].strike));
      chk($sformatf("tv%0d_idx", k), int'(bus.beat_idx), int'(tv[k].idx));
      chk($sformatf("tv%0d_led", k), int'(bus.led), int'(tv[k].led));
      chk($sformatf("tv%0d_done", k), int'(bus.bar_done), int'(tv[k].done));
    end

    // Full bar ramp
    step(1, 0, 0); step(0, 1, 0);
    nstr = 0; ndone = 0; done_at = -1; bad = 0;
    for (int c = 0; c <= 6600; c++) begin
      step(0, 0, 13'(c));
      exp_s = (c == 0 || c == 1236 || c == 2472 || c == 4120 || c == 4944);
      if (bus.strike !== exp_s) bad++;
      if (bus.strike) nstr++;
      if (bus.bar_done) begin ndone++; done_at = c; end
    end
    chk("ramp_strike_cycles", bad, 0);
    chk("ramp_strikes", nstr, 5);
    chk("ramp_bar_done_cnt", ndone, 1);
    chk("ramp_bar_done_at", done_at, 6600);
    chk("ramp_beat_idx", int'(bus.beat_idx), 5);

    // Paused count at a beat position
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 1000);
    chk("pause_pre_idx", int'(bus.beat_idx), 1);
    nstr = 0; moves = 0;
    for (int k = 0; k < 50; k++) begin
      pidx = bus.beat_idx;
      step(0, 0, 1236);
      if (bus.strike) nstr++;
      if (bus.beat_idx != pidx) moves++;
    end
    chk("pause_strikes", nstr, 1);
    chk("pause_idx_moves", moves, 1);
    chk("pause_idx", int'(bus.beat_idx), 2);

    // Strikes 300 cycles apart keep the LED lit, then exactly LED_LEN after the last
    posl[0] = 13'd1236; posl[1] = 13'd2472; posl[2] = 13'd4120; posl[3] = 13'd4944;
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 0);
    nstr = int'(bus.strike); lows = int'(!bus.led); cur = 13'd0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 299; k++) begin
        step(0, 0, cur);
        if (bus.strike) nstr++;
        if (!bus.led) lows++;
      end
      cur = posl[p];
      step(0, 0, cur);
      if (bus.strike) nstr++;
      if (!bus.led) lows++;
    end
    chk("led_train_strikes", nstr, 5);
    chk("led_train_low_cycles", lows, 0);
    lows = 0; nstr = 0;
    for (int k = 1; k < 1000; k++) begin
      step(0, 0, cur);
      if (!bus.led) lows++;
      if (bus.strike) nstr++;
    end
    chk("led_tail_low_cycles", lows, 0);
    chk("led_tail_strikes", nstr, 0);
    step(0, 0, cur);
    chk("led_off_at_1000", int'(bus.led), 0);

    // go mid-bar, and go colliding with a strike condition
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 1236); step(0, 0, 2472);
    step(0, 0, 3000);
    chk("go_pre_idx", int'(bus.beat_idx), 3);
    step(0, 1, 3000);
    chk("go_idx", int'(bus.beat_idx), 0);
    chk("go_strike", int'(bus.strike), 0);
    step(0, 0, 0);
    chk("go_beat0_strike", int'(bus.strike), 1);
    chk("go_beat0_idx", int'(bus.beat_idx), 1);
    step(0, 0, 1236); step(0, 0, 2472);
    step(0, 1, 4120);
    chk("go_vs_strike_strike", int'(bus.strike), 0);
    chk("go_vs_strike_idx", int'(bus.beat_idx), 0);
    step(0, 0, 0);
    chk("go_vs_strike_next", int'(bus.strike), 1);

    // Reset mid-bar with LED lit, then a ramp without go
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 1236);
    chk("rst_pre_idx", int'(bus.beat_idx), 2);
    chk("rst_pre_led", int'(bus.led), 1);
    step(1, 0, 1236);
    chk("rst_strike", int'(bus.strike), 0);
    chk("rst_idx", int'(bus.beat_idx), 0);
    chk("rst_led", int'(bus.led), 0);
    chk("rst_done", int'(bus.bar_done), 0);
    rampl[0] = 13'd0;    rampl[1] = 13'd1;    rampl[2] = 13'd1236; rampl[3] = 13'd1237;
    rampl[4] = 13'd2472; rampl[5] = 13'd4120; rampl[6] = 13'd4944; rampl[7] = 13'd6600;
    nz = 0;
    foreach (rampl[k]) begin
      step(0, 0, rampl[k]);
      if (bus.strike || bus.bar_done || bus.led || bus.beat_idx != 3'd0) nz++;
    end
    chk("idle_ramp_active_cycles", nz, 0);

    // Count drop without go rearms
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 1236); step(0, 0, 2472); step(0, 0, 4120);
    step(0, 0, 5000);
    chk("drop_pre_strike", int'(bus.strike), 1);
    chk("drop_pre_idx", int'(bus.beat_idx), 5);
    step(0, 0, 0);
    chk("drop_idx", int'(bus.beat_idx), 0);
    chk("drop_strike", int'(bus.strike), 0);
    step(0, 0, 0);
    chk("drop_beat0_strike", int'(bus.strike), 1);
    chk("drop_beat0_idx", int'(bus.beat_idx), 1);

    // Count past MAXCOUNT never signals bar_done
    step(0, 0, 1236); step(0, 0, 2472); step(0, 0, 4120); step(0, 0, 4944);
    chk("over_idx", int'(bus.beat_idx), 5);
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 6601);
      if (bus.bar_done) ndone++;
    end
    chk("over_bar_done", ndone, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clave_beat_decoder.md
CLAVE_BEAT_DECODER -- requirements
Module: clave_beat_decoder

Interface
REQ-001 Parameter MAXCOUNT, default 13'd6600, terminal value of the bar count.
REQ-002 Parameter LED_LEN, default 16'd1000, LED on-time in clk cycles after each strike.
REQ-003 Parameter POS0..POS4, defaults 0, 1236, 2472, 4120, 4944, count positions of the five 3-2 son clave beats.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 count  input  13  bar position from the bar counter; monotonic +0/+1 per cycle except on restart.
REQ-007 go  input  1  restart strobe, same signal that clears the bar counter.
REQ-008 strike  output  1  one-cycle pulse per clave beat.
REQ-009 beat_idx  output  3  index (0..4) of the next beat awaited; 5 once all five are struck.
REQ-010 led  output  1  high for LED_LEN cycles after each strike.
REQ-011 bar_done  output  1  one-cycle pulse when the bar completes.

Function
REQ-012 FSM states IDLE, ARMED, DONE; reset state IDLE.
REQ-013 IDLE: outputs quiet; go=1 -> ARMED with beat_idx=0.
REQ-014 ARMED: when count >= POS[beat_idx], strike=1 on the next cycle (1-cycle latency) and beat_idx increments.
REQ-015 Strike on beat_idx 4 -> DONE with beat_idx=5.
REQ-016 At most one strike per cycle; each beat is struck at most once per bar.
REQ-017 DONE: first cycle with count == MAXCOUNT gives bar_done=1 for one cycle; then DONE holds.
REQ-018 go=1 in any non-reset state -> ARMED, beat_idx=0; an aborted pending strike does not fire.
REQ-019 go and a strike condition in the same cycle: go wins and no strike is issued that cycle.
REQ-020 Wrap: in ARMED or DONE, count < previous-cycle count with go=0 -> ARMED, beat_idx=0.
REQ-021 count pausing (unchanged) causes no state change and no repeated strike.
REQ-022 led: each strike loads a 16-bit down-counter with LED_LEN; led = (counter != 0).
REQ-023 A strike while led is already high retriggers the counter to the full LED_LEN.
REQ-024 led keeps running across go and wrap; only reset clears it.
REQ-025 Comparisons are unsigned 13-bit; count > MAXCOUNT is treated as no bar_done.

Reset
REQ-026 reset=1 at any clock edge gives state=IDLE, beat_idx=0, strike=0, led=0, bar_done=0, LED counter=0, previous-count register=0.
REQ-027 reset has priority over go, wrap and strike; reset mid-bar discards all progress.

Structure
REQ-028 Package clave_pkg holds MAXCOUNT, POS0..POS4 defaults, LED_LEN default and the FSM state type.
REQ-029 One sub-module, led_stretch (retriggerable 16-bit pulse stretcher: trig in, led out, LED_LEN parameter), is instantiated once.
REQ-030 All outputs are registered; no combinational path runs from count or go to any output.

Verification
REQ-031 reset, go, then count ramps 0..6600 one per cycle -> strikes one cycle after count = 0, 1236, 2472, 4120, 4944; bar_done one cycle after count=6600; beat_idx ends at 5.
REQ-032 count held at 1236 for 50 cycles -> exactly one strike; beat_idx moves 1->2 once.
REQ-033 LED_LEN=1000, strikes 300 cycles apart -> led stays high continuously, then low exactly 1000 cycles after the last strike.
REQ-034 go asserted at count=3000 (beat_idx=3) -> beat_idx=0 next cycle; strike issued for the count=0 beat one cycle after go deasserts.
REQ-035 reset asserted while led is high and beat_idx=2 -> the next cycle has all outputs 0 and state IDLE; ramp without go -> no strikes.
REQ-036 count drops from 5000 to 0 with go=0 -> rearm, beat_idx=0, strike for beat 0 follows one cycle later.
